// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one registered signed compare unit among NREQ requesters.
// Optional watchdog on the compare result enabled by defining CMP_ARB_TIMEOUT_EN.
module cmp_share_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    input  logic [NREQ*2-1:0]     req_fun_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]      cmp_a_o,
    output logic [WIDTH-1:0]      cmp_b_o,
    output logic [1:0]            cmp_fun_o,
    output logic                  cmp_en_o,
    input  logic [WIDTH-1:0]      cmp_out_i,
    input  logic                  cmp_flag_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IDW-1:0]        rsp_id_o,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic                  rsp_err_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    state_e state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, gnt_id;
    logic [IDW:0] scan;
    logic gnt_any, tmo;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [1:0] fun_q, fun_d;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("cmp_share_arbiter: unsupported parameters");
    end

    // Scan downward so the requester closest to ptr_q (mod NREQ) is the last to overwrite.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        scan    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(i);
            if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
            if (rst_n && req_valid_i[scan[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = scan[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        data_d      = data_q;
        req_ready_o = '0;
        cmp_en_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: if (gnt_any) begin
                req_ready_o[gnt_id] = 1'b1;
                a_d     = req_a_i[gnt_id*WIDTH +: WIDTH];
                b_d     = req_b_i[gnt_id*WIDTH +: WIDTH];
                fun_d   = req_fun_i[gnt_id*2 +: 2];
                id_d    = gnt_id;
                ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                cmp_en_o = 1'b1;
                state_d  = WAIT;
            end
            WAIT: if (cmp_flag_i || tmo) begin
                data_d  = cmp_flag_i ? cmp_out_i : '0;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = rsp_ready_i ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            data_q  <= data_d;
        end
    end

    assign cmp_a_o    = a_q;
    assign cmp_b_o    = b_q;
    assign cmp_fun_o  = fun_q;
    assign rsp_id_o   = id_q;
    assign rsp_data_o = data_q;

`ifdef CMP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic err_q;

    // Counter is zero whenever WAIT is entered; fires on the TIMEOUT-th flagless WAIT cycle.
    assign tmo = (state_q == WAIT) && !cmp_flag_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == WAIT) ? cnt_q + CW'(1) : '0;
            err_q <= (state_q == IDLE && gnt_any) ? 1'b0 : (tmo ? 1'b1 : err_q);
        end
    end

    assign rsp_err_o = err_q;
`else
    assign tmo       = 1'b0;
    assign rsp_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed bench with a transaction-level model of the arbiter and a registered compare unit.
module tb_cmp_share_arbiter;
    localparam int WIDTH = 16, NREQ = 4, IDW = 2, TIMEOUT = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NREQ-1:0] req_valid = '0, req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ*2-1:0] req_fun;
    logic [WIDTH-1:0] ta[NREQ], tbv[NREQ];
    logic [1:0] tf[NREQ];
    logic [WIDTH-1:0] cmp_a, cmp_b, cmp_out = '0;
    logic [1:0] cmp_fun;
    logic cmp_en, cmp_flag = 1'b0;
    logic rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [IDW-1:0] rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic force0 = 1'b0;
    int n_chk = 0, n_pass = 0, cyc = 0;

    int m_ptr = 0, m_age = 0, m_id = 0;
    bit m_busy = 0, m_err = 0, m_tmo = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0, m_data = '0;
    logic [1:0] m_fun = '0;

    for (genvar g = 0; g < NREQ; g++) begin : g_pk
        assign req_a[g*WIDTH +: WIDTH] = ta[g];
        assign req_b[g*WIDTH +: WIDTH] = tbv[g];
        assign req_fun[g*2 +: 2]       = tf[g];
    end

    cmp_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_fun_i(req_fun),
        .req_ready_o(req_ready),
        .cmp_a_o(cmp_a), .cmp_b_o(cmp_b), .cmp_fun_o(cmp_fun), .cmp_en_o(cmp_en),
        .cmp_out_i(cmp_out), .cmp_flag_i(cmp_flag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [WIDTH-1:0] cmpf(input logic signed [WIDTH-1:0] x,
                                              input logic signed [WIDTH-1:0] y,
                                              input logic [1:0] fn);
        if (fn == 2'd1) return (x == y) ? WIDTH'(1) : '0;
        if (fn == 2'd2) return (x > y) ? WIDTH'(2) : '0;
        if (fn == 2'd3) return (x < y) ? WIDTH'(3) : '0;
        return '0;
    endfunction

    // Registered compare unit: result and flag one cycle after enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_flag <= 1'b0;
            cmp_out  <= '0;
        end else begin
            cmp_flag <= cmp_en & ~force0;
            if (cmp_en) cmp_out <= cmpf(cmp_a, cmp_b, cmp_fun);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: one outstanding transaction, aged in cycles since its accept edge.
    always @(negedge clk) begin
        int ek, rsp_at;
        logic [NREQ-1:0] er;
        bit ev;
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; m_age = 0; m_id = 0; m_err = 0; m_tmo = 0;
            m_a = '0; m_b = '0; m_fun = '0; m_data = '0;
        end
        ek = -1;
        er = '0;
        if (!m_busy && rst_n)
            for (int i = 0; i < NREQ; i++)
                if (ek < 0 && req_valid[(m_ptr + i) % NREQ]) ek = (m_ptr + i) % NREQ;
        if (ek >= 0) er[ek] = 1'b1;
        rsp_at = m_tmo ? 2 + TIMEOUT : 3;
        ev = m_busy && m_age >= rsp_at;
        chk("req_ready", req_ready, er);
        chk("cmp_en", cmp_en, m_busy && m_age == 1);
        chk("cmp_a", cmp_a, m_a);
        chk("cmp_b", cmp_b, m_b);
        chk("cmp_fun", cmp_fun, m_fun);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_data", rsp_data, m_data);
        end
        chk("rsp_err", rsp_err, m_err);
        if (rst_n) begin
            if (!m_busy) begin
                if (ek >= 0) begin
                    m_busy = 1; m_age = 1; m_id = ek; m_ptr = (ek + 1) % NREQ;
                    m_a = ta[ek]; m_b = tbv[ek]; m_fun = tf[ek];
                    m_err = 0; m_tmo = force0;
                    m_data = force0 ? '0 : cmpf(ta[ek], tbv[ek], tf[ek]);
                end
            end else if (ev && rsp_ready) m_busy = 0;
            else begin
                m_age++;
                if (m_tmo && m_age == 2 + TIMEOUT) m_err = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int a, input int b, input int f);
        ta[k] = WIDTH'(a); tbv[k] = WIDTH'(b); tf[k] = 2'(f);
    endtask

    task automatic wait_ready(output int k);
        k = -1;
        for (int n = 0; n < 20 && k < 0; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) k = i;
        end
        chk("ready_seen", k >= 0, 1);
    endtask

    task automatic wait_rsp(output int n);
        bit seen = 0;
        n = 0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            seen = rsp_valid;
        end
        chk("rsp_seen", seen, 1);
    endtask

    initial begin
        int k, n;
        int rt[5];
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        tick(); rst_n = 1'b1; tick();
        // GT from requester 2 alone, cycle-exact latency
        set_req(2, 5, -3, 2); req_valid = 4'b0100;
        @(negedge clk); chk("t1_ready", req_ready, 4'b0100);
        tick(); req_valid = '0;
        @(negedge clk); chk("t1_cmp_en", cmp_en, 1); chk("t1_cmp_a", cmp_a, 5);
        @(negedge clk); chk("t1_no_rsp_c2", rsp_valid, 0);
        @(negedge clk); chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 2); chk("t1_rsp_data", rsp_data, 2);
        tick();
        // All requesters valid from a fresh pointer
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 7, 7, 1);
        req_valid = 4'hF;
        for (int j = 0; j < 5; j++) begin
            wait_ready(k);
            chk("t2_order", k, j % NREQ);
            wait_rsp(n);
            chk("t2_data", rsp_data, 1);
            rt[j] = cyc;
            if (j > 0) chk("t2_gap", rt[j] - rt[j-1], 4);
        end
        tick(); req_valid = '0;
        // LT with response back-pressure
        set_req(1, -8, 3, 3); rsp_ready = 1'b0; req_valid = 4'b0010;
        wait_ready(k); chk("t3_grant", k, 1);
        tick(); req_valid = 4'b0001;
        wait_rsp(n);
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_valid", rsp_valid, 1); chk("t3_hold_id", rsp_id, 1);
            chk("t3_hold_data", rsp_data, 3); chk("t3_no_ready", req_ready, 0);
        end
        tick(); req_valid = '0; rsp_ready = 1'b1;
        tick();
        // NOP still round-trips
        set_req(3, 1, 1, 0); req_valid = 4'b1000;
        wait_ready(k); chk("t4_grant", k, 3);
        tick(); req_valid = '0;
        wait_rsp(n);
        chk("t4_lat", n, 3); chk("t4_data", rsp_data, 0); chk("t4_err", rsp_err, 0);
        tick();
        // Reset while waiting on the compare unit
        set_req(0, 4, 2, 2); req_valid = 4'b0001;
        wait_ready(k);
        tick(); req_valid = '0;
        tick(); rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", rsp_valid, 0); chk("t5_rst_en", cmp_en, 0);
        chk("t5_rst_a", cmp_a, 0); chk("t5_rst_id", rsp_id, 0); chk("t5_rst_data", rsp_data, 0);
        tick(); rst_n = 1'b1; set_req(3, 9, 9, 1); req_valid = 4'b1001;
        @(negedge clk); chk("t5_ready", req_ready, 4'b0001); chk("t5_no_rsp", rsp_valid, 0);
        tick(); req_valid = '0;
        wait_rsp(n);
        chk("t5_id", rsp_id, 0); chk("t5_data", rsp_data, 2);
        tick();
`ifdef CMP_ARB_TIMEOUT_EN
        // Compare unit never answers
        force0 = 1'b1; set_req(2, 1, 2, 3); req_valid = 4'b0100;
        wait_ready(k);
        tick(); req_valid = '0;
        wait_rsp(n);
        chk("t6_lat", n, 2 + TIMEOUT); chk("t6_err", rsp_err, 1); chk("t6_data", rsp_data, 0);
        tick(); force0 = 1'b0;
        set_req(1, 3, 1, 2); req_valid = 4'b0010;
        wait_ready(k);
        tick(); req_valid = '0;
        @(negedge clk); chk("t6_err_clr", rsp_err, 0);
        wait_rsp(n);
        chk("t6_data2", rsp_data, 2);
        tick();
`endif
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
